z80_io_master: RTL and testbench

- Bus initiator for the VDP's Z80-style I/O port.
- Turns a valid/ready command stream (port 0-3, read/write, data) into I/O cycles with iorq_n, rd_n and wr_n strobes at base address PORT_BASE.
- Used in the board self-test loader and in the bench to exercise the pin-level CPU interface (pin filter, cs decode, REQ/WRT capture).
- Returns read data and completion status on a one-cycle response pulse.

---
 rtl/z80_io_master_if.sv | 32 +++
 rtl/z80_io_master.sv | 155 +++++++++++++++
 tb/tb_z80_io_master.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/z80_io_master_if.sv
// Command, Z80-style I/O pin and response signals of the I/O bus initiator.
// The master modport is the initiator side; the slave modport is the command source and bus target.
interface z80_io_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [1:0] cmd_port;
  logic [7:0] cmd_data;
  logic [7:0] io_addr;
  logic       iorq_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] io_dout;
  logic       io_doe;
  logic [7:0] io_din;
  logic       wait_n;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;

  modport master (
    input  cmd_valid, cmd_wr, cmd_port, cmd_data, io_din, wait_n,
    output cmd_ready, io_addr, iorq_n, rd_n, wr_n, io_dout, io_doe,
    output rsp_valid, rsp_data, rsp_timeout
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_port, cmd_data, io_din, wait_n,
    input  cmd_ready, io_addr, iorq_n, rd_n, wr_n, io_dout, io_doe,
    input  rsp_valid, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/z80_io_master.sv
// Bus initiator turning a valid/ready command stream into Z80-style I/O cycles
// (setup, strobe, hold, recover) with wait-state extension and timeout abort.
module z80_io_master #(
  parameter logic [7:0]  PORT_BASE   = 8'h98,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned ACTIVE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned RECOVER_CYC = 3,
  parameter int unsigned WAIT_MAX    = 255
) (
  input logic             clk,
  input logic             reset,
  z80_io_master_if.master bus
);

  localparam int unsigned M1     = (SETUP_CYC > ACTIVE_CYC) ? SETUP_CYC : ACTIVE_CYC;
  localparam int unsigned M2     = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
  localparam int unsigned CntMax = (M1 > M2) ? M1 : M2;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned WaitW  = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  localparam logic [CntW-1:0]  SetupLd   = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0]  ActiveLd  = CntW'(ACTIVE_CYC - 1);
  localparam logic [CntW-1:0]  HoldLd    = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0]  RecoverLd = CntW'(RECOVER_CYC - 1);
  localparam logic [WaitW-1:0] WaitLim   = WaitW'(WAIT_MAX);

  typedef enum logic [2:0] {StIdle, StSetup, StActive, StHold, StRecover} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             wr_q, wr_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       dout_q, dout_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             cmd_ready;
  logic             accept;

  // Held low while reset is asserted so no command is taken in the reset cycle.
  assign cmd_ready = (state_q == StIdle) && !reset;
  assign accept    = bus.cmd_valid && cmd_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    dout_d        = dout_q;
    rdata_d       = rdata_q;
    timeout_d     = timeout_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StSetup;
          cnt_d     = SetupLd;
          wait_d    = '0;
          timeout_d = 1'b0;
          rdata_d   = '0;
          wr_d      = bus.cmd_wr;
          addr_d    = PORT_BASE | {6'b0, bus.cmd_port};
          if (bus.cmd_wr) dout_d = bus.cmd_data;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StActive;
          cnt_d   = ActiveLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StActive: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (bus.wait_n) begin
          rdata_d = bus.io_din;
          state_d = StHold;
          cnt_d   = HoldLd;
        end else if (WAIT_MAX != 0 && wait_q == WaitLim) begin
          // Target never released wait: abort and drop any data.
          timeout_d = 1'b1;
          rdata_d   = '0;
          state_d   = StHold;
          cnt_d     = HoldLd;
        end else if (WAIT_MAX != 0) begin
          wait_d = wait_q + 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d       = StRecover;
          cnt_d         = RecoverLd;
          rsp_data_d    = (!wr_q && !timeout_q) ? rdata_q : 8'h00;
          rsp_timeout_d = timeout_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRecover: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      wait_q        <= '0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      dout_q        <= '0;
      rdata_q       <= '0;
      timeout_q     <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wait_q        <= wait_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      dout_q        <= dout_d;
      rdata_q       <= rdata_d;
      timeout_q     <= timeout_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.io_addr     = addr_q;
  assign bus.io_dout     = dout_q;
  assign bus.iorq_n      = (state_q != StActive);
  assign bus.rd_n        = !((state_q == StActive) && !wr_q);
  assign bus.wr_n        = !((state_q == StActive) && wr_q);
  assign bus.io_doe      = wr_q && ((state_q == StSetup) || (state_q == StActive) ||
                                    (state_q == StHold));
  assign bus.rsp_valid   = (state_q == StRecover) && (cnt_q == RecoverLd);
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_z80_io_master.sv
// Directed bench for z80_io_master: write/read cycles, wait extension, timeout,
// back-to-back commands and mid-cycle reset, with hand-computed expectations.
module tb_z80_io_master;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_viol   = 0;

  z80_io_master_if bus ();

  z80_io_master dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Strobe rules watched on every cycle.
  always @(negedge clk) begin
    if (!reset && !bus.rd_n && !bus.wr_n) n_viol++;
    if (!reset && (!bus.rd_n || !bus.wr_n) && bus.iorq_n) n_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-transaction trace summary.
  int         n_iorq, f_iorq, l_iorq, n_rd, n_wr, n_doe, f_doe, l_doe;
  int         n_rsp, rsp_cyc, rdy_cyc;
  logic [7:0] rsp_d, addr1, dout1, addr_end, rsp_d_end;
  logic       rsp_to, acc0;

  // waits < 0 means wait_n stuck low. Reads also pull wait_n low early, which must be ignored.
  task automatic run_txn(input logic wr, input logic [1:0] port, input logic [7:0] data,
                         input logic [7:0] din, input int waits, input int ncyc);
    n_iorq = 0; f_iorq = -1; l_iorq = -1; n_rd = 0; n_wr = 0;
    n_doe = 0; f_doe = -1; l_doe = -1; n_rsp = 0; rsp_cyc = -1; rdy_cyc = -1;
    rsp_d = 'x; rsp_to = 1'bx;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_wr = wr; bus.cmd_port = port; bus.cmd_data = data;
    bus.wait_n = 1'b1;
    @(negedge clk);
    acc0 = bus.cmd_valid && bus.cmd_ready;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0; bus.cmd_wr = ~wr; bus.cmd_port = ~port; bus.cmd_data = ~data;
      if (waits < 0) bus.wait_n = 1'b0;
      else bus.wait_n = !(c >= (wr ? 6 : 1) && c <= 5 + waits);
      bus.io_din = (waits < 0 || c == 6 + waits) ? din : 8'hEE;
      @(negedge clk);
      if (!bus.iorq_n) begin n_iorq++; if (f_iorq < 0) f_iorq = c; l_iorq = c; end
      if (!bus.rd_n) n_rd++;
      if (!bus.wr_n) n_wr++;
      if (bus.io_doe) begin n_doe++; if (f_doe < 0) f_doe = c; l_doe = c; end
      if (bus.rsp_valid) begin
        n_rsp++;
        if (rsp_cyc < 0) begin rsp_cyc = c; rsp_d = bus.rsp_data; rsp_to = bus.rsp_timeout; end
      end
      if (bus.cmd_ready && rdy_cyc < 0) rdy_cyc = c;
      if (c == 1) begin addr1 = bus.io_addr; dout1 = bus.io_dout; end
      if (c == ncyc) begin addr_end = bus.io_addr; rsp_d_end = bus.rsp_data; end
    end
    bus.wait_n = 1'b1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!bus.cmd_ready && k < 400) begin @(negedge clk); k++; end
    check("ready_bound", 32'(bus.cmd_ready), 1);
  endtask

  int         n_acc;
  int         acc_cyc [3];
  logic [7:0] addr_b, dout_b;
  logic       doe_b;

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_port = 2'd0; bus.cmd_data = 8'h00;
    bus.io_din = 8'h00; bus.wait_n = 1'b1;

    // Reset values
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready", 32'(bus.cmd_ready), 0);
    check("rst_strobes", 32'({bus.iorq_n, bus.rd_n, bus.wr_n}), 'b111);
    check("rst_addr", 32'(bus.io_addr), 0);
    check("rst_dout_doe", 32'({bus.io_dout, bus.io_doe}), 0);
    check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_data, bus.rsp_timeout}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.cmd_ready), 1);

    // 1: write port 1, 0xA5, no waits
    run_txn(1'b1, 2'd1, 8'hA5, 8'h00, 0, 12);
    check("wr_acc", 32'(acc0), 1);
    check("wr_addr", 32'(addr1), 'h99);
    check("wr_dout", 32'(dout1), 'hA5);
    check("wr_iorq_n", 32'(n_iorq), 4);
    check("wr_iorq_span", 32'({f_iorq[7:0], l_iorq[7:0]}), 'h0306);
    check("wr_wr_n", 32'(n_wr), 4);
    check("wr_rd_n", 32'(n_rd), 0);
    check("wr_doe_cnt", 32'(n_doe), 7);
    check("wr_doe_span", 32'({f_doe[7:0], l_doe[7:0]}), 'h0107);
    check("wr_rsp_cyc", 32'(rsp_cyc), 8);
    check("wr_rsp_cnt", 32'(n_rsp), 1);
    check("wr_rsp_val", 32'({rsp_d, rsp_to}), 0);
    check("wr_ready", 32'(rdy_cyc), 11);
    check("wr_addr_held", 32'(addr_end), 'h99);

    // 2: read port 0, io_din 0x3C on last ACTIVE cycle
    run_txn(1'b0, 2'd0, 8'h00, 8'h3C, 0, 12);
    check("rd_addr", 32'(addr1), 'h98);
    check("rd_rd_n", 32'(n_rd), 4);
    check("rd_wr_n", 32'(n_wr), 0);
    check("rd_doe", 32'(n_doe), 0);
    check("rd_rsp_cyc", 32'(rsp_cyc), 8);
    check("rd_rsp_val", 32'({rsp_d, rsp_to}), 'h3C << 1);
    check("rd_rsp_hold", 32'(rsp_d_end), 'h3C);

    // 3: read with 5 wait cycles at count end
    run_txn(1'b0, 2'd2, 8'h00, 8'h5A, 5, 17);
    check("wt_addr", 32'(addr1), 'h9A);
    check("wt_iorq_n", 32'(n_iorq), 9);
    check("wt_iorq_span", 32'({f_iorq[7:0], l_iorq[7:0]}), 'h030B);
    check("wt_rsp_cyc", 32'(rsp_cyc), 13);
    check("wt_rsp_val", 32'({rsp_d, rsp_to}), 'h5A << 1);
    check("wt_ready", 32'(rdy_cyc), 16);

    // 4: wait_n stuck low -> timeout after 255 extensions
    run_txn(1'b0, 2'd3, 8'h00, 8'h77, -1, 270);
    check("to_iorq_n", 32'(n_iorq), 259);
    check("to_rsp_cyc", 32'(rsp_cyc), 263);
    check("to_rsp_cnt", 32'(n_rsp), 1);
    check("to_rsp_val", 32'({rsp_d, rsp_to}), 1);
    check("to_ready", 32'(rdy_cyc), 266);
    check("to_flag_held", 32'(bus.rsp_timeout), 1);

    // 5: back-to-back with cmd_valid held high
    wait_ready();
    n_acc = 0;
    addr_b = 'x; dout_b = 'x; doe_b = 1'bx;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1;
      if (n_acc == 0) begin bus.cmd_wr = 1'b0; bus.cmd_port = 2'd2; bus.cmd_data = 8'h11; end
      else begin bus.cmd_wr = 1'b1; bus.cmd_port = 2'd3; bus.cmd_data = 8'h5A; end
      @(negedge clk);
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (n_acc < 3) acc_cyc[n_acc] = c;
        n_acc++;
      end
      if (c == 12) begin addr_b = bus.io_addr; dout_b = bus.io_dout; doe_b = bus.io_doe; end
    end
    bus.cmd_valid = 1'b0;
    check("b2b_accepts", 32'(n_acc), 3);
    check("b2b_acc0", 32'(acc_cyc[0]), 0);
    check("b2b_acc1", 32'(acc_cyc[1]), 11);
    check("b2b_acc2", 32'(acc_cyc[2]), 22);
    check("b2b_addr", 32'(addr_b), 'h9B);
    check("b2b_dout", 32'({dout_b, doe_b}), ('h5A << 1) | 1);
    wait_ready();

    // 6: reset during ACTIVE of a write
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_port = 2'd0; bus.cmd_data = 8'hC3;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mr_active", 32'({bus.iorq_n, bus.wr_n, bus.io_doe}), 'b001);
    check("mr_ready_low", 32'(bus.cmd_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mr_strobes", 32'({bus.iorq_n, bus.rd_n, bus.wr_n}), 'b111);
    check("mr_doe_addr", 32'({bus.io_doe, bus.io_addr}), 0);
    check("mr_ready", 32'(bus.cmd_ready), 1);
    n_rsp = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.rsp_valid) n_rsp++;
      @(negedge clk);
    end
    check("mr_no_rsp", 32'(n_rsp), 0);

    check("strobe_rules", 32'(n_viol), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
